// File: rtl/jpeg_idct_pkg.sv
// Shared definitions for the IDCT transpose buffer.
//   Read FSM state encoding, block geometry constants and the replay-cursor
//   type with its advance helper (order: (c0,h0),(c0,h1),(c1,h0)...(c7,h1)).
package jpeg_idct_pkg;

  localparam int unsigned BLOCK_SIZE    = 64;
  localparam int unsigned COLS          = 8;
  localparam int unsigned BEATS_PER_COL = 2;
  localparam int unsigned LANES         = 4;
  localparam int unsigned IDX_W         = 6;
  localparam int unsigned CNT_W         = 7;
  localparam int unsigned COL_W         = 3;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_ISSUE = 1'b1
  } rd_state_e;

  // Replay cursor: column c, half h (rows 4h..4h+3)
  typedef struct packed {
    logic [COL_W-1:0] c;
    logic             h;
  } beat_pos_t;

  // Advance h first, then c
  function automatic beat_pos_t next_pos(input beat_pos_t p);
    beat_pos_t n;
    n = p;
    if (!p.h) begin
      n.h = 1'b1;
    end else begin
      n.h = 1'b0;
      n.c = p.c + COL_W'(1);
    end
    return n;
  endfunction

  function automatic logic is_last_pos(input beat_pos_t p);
    return (p.c == COL_W'(COLS - 1)) && (p.h == 1'(BEATS_PER_COL - 1));
  endfunction

endpackage

// File: rtl/jpeg_idct_tbank.sv
// One 64-entry coefficient bank: single synchronous write port and four
// combinational read ports (one per output lane). Contents are not reset.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address {row,col}
//   wdata_i  write data
//   raddr_i  four read addresses
//   rdata_o  four read data words
module jpeg_idct_tbank
  import jpeg_idct_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                              clk_i,
  input  logic                              we_i,
  input  logic [IDX_W-1:0]                  waddr_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  input  logic [LANES-1:0][IDX_W-1:0]       raddr_i,
  output logic [LANES-1:0][DATA_W-1:0]      rdata_o
);

  logic [DATA_W-1:0] mem_q [BLOCK_SIZE];

  // Storage write
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read lanes
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      rdata_o[k] = mem_q[raddr_i[k]];
    end
  end

endmodule

// File: rtl/jpeg_idct_transpose.sv
// Transpose buffer between the row and column IDCT passes.
// Row results are written one per cycle by {row,col} index into a ping-pong
// bank pair; each completed block is replayed column-wise, 4 rows per beat,
// 2 beats per column.
// Optional feature macro: JPEG_IDCT_TRANSPOSE_CLAMP_EN (saturate inputs to
// signed 16 bits before storage).
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   img_start_i                  synchronous flush of counters/flags/overflow
//   inport_valid_i/data_i/idx_i  row-pass result write
//   outport_valid_o/accept_i     column beat handshake
//   outport_data0..3_o           rows 4h+0..4h+3 of column outport_idx_o
//   overflow_o                   sticky: write arrived with both banks full
module jpeg_idct_transpose
  import jpeg_idct_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              img_start_i,
  input  logic              inport_valid_i,
  input  logic [DATA_W-1:0] inport_data_i,
  input  logic [IDX_W-1:0]  inport_idx_i,
  output logic              outport_valid_o,
  input  logic              outport_accept_i,
  output logic [DATA_W-1:0] outport_data0_o,
  output logic [DATA_W-1:0] outport_data1_o,
  output logic [DATA_W-1:0] outport_data2_o,
  output logic [DATA_W-1:0] outport_data3_o,
  output logic [COL_W-1:0]  outport_idx_o,
  output logic              overflow_o
);

  logic                          wr_bank_q, wr_bank_d;
  logic                          rd_bank_q, rd_bank_d;
  logic [1:0]                    full_q, full_d, full_clr;
  logic [1:0][CNT_W-1:0]         cnt_q, cnt_d;
  logic                          overflow_q, overflow_d;
  logic                          wr_en;
  logic [DATA_W-1:0]             wdata;

  rd_state_e                     state_q, state_d;
  beat_pos_t                     pos_q, pos_d, ld_pos;
  logic                          valid_q, valid_d, load, ld_bank;
  logic [LANES-1:0][DATA_W-1:0]  data_q, data_d;
  logic [COL_W-1:0]              idx_q, idx_d;
  logic [LANES-1:0][IDX_W-1:0]   raddr;
  logic [LANES-1:0][DATA_W-1:0]  rdata0, rdata1;

  // Input conditioning
`ifdef JPEG_IDCT_TRANSPOSE_CLAMP_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(32767);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-32768);
  always_comb begin
    wdata = inport_data_i;
    if ($signed(inport_data_i) > SAT_MAX)      wdata = SAT_MAX;
    else if ($signed(inport_data_i) < SAT_MIN) wdata = SAT_MIN;
  end
`else
  assign wdata = inport_data_i;
`endif

  // Ping-pong banks; a full bank is never the write target
  jpeg_idct_tbank #(.DATA_W(DATA_W)) u_bank0 (
    .clk_i   (clk_i),
    .we_i    (wr_en && !wr_bank_q && !img_start_i),
    .waddr_i (inport_idx_i),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata0)
  );

  jpeg_idct_tbank #(.DATA_W(DATA_W)) u_bank1 (
    .clk_i   (clk_i),
    .we_i    (wr_en && wr_bank_q && !img_start_i),
    .waddr_i (inport_idx_i),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata1)
  );

  // Write side: count-based block completion, drop on overflow
  always_comb begin
    full_d     = full_q & ~full_clr;
    cnt_d      = cnt_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (inport_valid_i) begin
      if (full_q[wr_bank_q]) begin
        overflow_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (cnt_q[wr_bank_q] == CNT_W'(BLOCK_SIZE - 1)) begin
          full_d[wr_bank_q] = 1'b1;
          cnt_d[wr_bank_q]  = '0;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          cnt_d[wr_bank_q] = cnt_q[wr_bank_q] + CNT_W'(1);
        end
      end
    end
  end

  // Read FSM: decides which beat (bank, position) to load into the output regs
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    rd_bank_d = rd_bank_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    full_clr  = '0;
    load      = 1'b0;
    ld_bank   = rd_bank_q;
    ld_pos    = pos_q;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = RD_ISSUE;
          load    = 1'b1;
          ld_pos  = '0;
        end
      end
      RD_ISSUE: begin
        if (valid_q && outport_accept_i) begin
          if (is_last_pos(pos_q)) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            ld_bank             = ~rd_bank_q;
            ld_pos              = '0;
            if (full_q[~rd_bank_q]) begin
              load = 1'b1;
            end else begin
              state_d = RD_IDLE;
              valid_d = 1'b0;
              pos_d   = '0;
            end
          end else begin
            load   = 1'b1;
            ld_pos = next_pos(pos_q);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (load) begin
      valid_d = 1'b1;
      pos_d   = ld_pos;
      idx_d   = ld_pos.c;
    end
  end

  // Lane k reads row 4h+k of column c: address {h, k, c}
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      raddr[k] = {ld_pos.h, 2'(k), ld_pos.c};
    end
  end

  always_comb begin
    data_d = data_q;
    if (load) data_d = ld_bank ? rdata1 : rdata0;
  end

  // State registers; img_start_i flushes to the reset state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      state_q    <= RD_IDLE;
      pos_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
    end else if (img_start_i) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      state_q    <= RD_IDLE;
      pos_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      pos_q      <= pos_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
    end
  end

  assign outport_valid_o = valid_q;
  assign outport_data0_o = data_q[0];
  assign outport_data1_o = data_q[1];
  assign outport_data2_o = data_q[2];
  assign outport_data3_o = data_q[3];
  assign outport_idx_o   = idx_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_jpeg_idct_transpose.sv
// Scoreboard bench for jpeg_idct_transpose: a block-level model (two 8x8
// buffers, pending-block count) pushes expected column beats; a monitor pops
// and compares them as the DUT presents beats.
module tb_jpeg_idct_transpose;

  localparam int unsigned DW    = 32;
  localparam int          LIMIT = 4000;

  typedef struct packed {
    logic [2:0]         c;
    logic [3:0][DW-1:0] d;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          img_start_i;
  logic          inport_valid_i;
  logic [DW-1:0] inport_data_i;
  logic [5:0]    inport_idx_i;
  logic          outport_valid_o;
  logic          outport_accept_i;
  logic [DW-1:0] outport_data0_o, outport_data1_o, outport_data2_o, outport_data3_o;
  logic [2:0]    outport_idx_o;
  logic          overflow_o;

  jpeg_idct_transpose #(.DATA_W(DW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .img_start_i      (img_start_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_idx_i     (inport_idx_i),
    .outport_valid_o  (outport_valid_o),
    .outport_accept_i (outport_accept_i),
    .outport_data0_o  (outport_data0_o),
    .outport_data1_o  (outport_data1_o),
    .outport_data2_o  (outport_data2_o),
    .outport_data3_o  (outport_data3_o),
    .outport_idx_o    (outport_idx_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int      checks = 0;
  int      errors = 0;
  beat_t   exp_q[$];
  logic [DW-1:0] mdl_mem [2][64];
  logic    mdl_wb;
  int      blk_cnt, pending, beat_n;
  logic    ovf_exp;
  int      acc_mode;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] cond(input logic [DW-1:0] d);
`ifdef JPEG_IDCT_TRANSPOSE_CLAMP_EN
    if ($signed(d) > 32767)  return 32'h0000_7FFF;
    if ($signed(d) < -32768) return 32'hFFFF_8000;
`endif
    return d;
  endfunction

  // Model + monitor, evaluated mid-cycle for the upcoming clock edge
  always @(negedge clk_i) begin
    beat_t act_b, b;
    logic  drained;
    if (rst_i || img_start_i) begin
      blk_cnt = 0; pending = 0; beat_n = 0; ovf_exp = 1'b0; mdl_wb = 1'b0;
      exp_q.delete();
    end else begin
      chk("overflow", 160'(overflow_o), 160'(ovf_exp));
      drained = 1'b0;
      if (outport_valid_o) begin
        act_b.c = outport_idx_o;
        act_b.d[0] = outport_data0_o; act_b.d[1] = outport_data1_o;
        act_b.d[2] = outport_data2_o; act_b.d[3] = outport_data3_o;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_beat: got idx %0d data0 %0h, no beat expected", outport_idx_o, outport_data0_o);
        end else begin
          chk("beat", 160'(act_b), 160'(exp_q[0]));
          if (outport_accept_i) begin
            void'(exp_q.pop_front());
            beat_n++;
            if (beat_n == 16) begin beat_n = 0; drained = 1'b1; end
          end
        end
      end
      if (inport_valid_i) begin
        if (pending == 2) begin
          ovf_exp = 1'b1;
        end else begin
          mdl_mem[mdl_wb][inport_idx_i] = cond(inport_data_i);
          blk_cnt++;
          if (blk_cnt == 64) begin
            for (int c = 0; c < 8; c++)
              for (int h = 0; h < 2; h++) begin
                b.c = 3'(c);
                for (int k = 0; k < 4; k++) b.d[k] = mdl_mem[mdl_wb][(4*h+k)*8+c];
                exp_q.push_back(b);
              end
            blk_cnt = 0; pending++; mdl_wb = ~mdl_wb;
          end
        end
      end
      if (drained) pending--;
    end
  end

  // Accept driver: 0 = always, 1 = never, 2 = toggle, 3 = random
  initial begin
    outport_accept_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (acc_mode)
        0: outport_accept_i = 1'b1;
        1: outport_accept_i = 1'b0;
        2: outport_accept_i = ~outport_accept_i;
        default: outport_accept_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic wr(input logic [5:0] idx, input logic [DW-1:0] d);
    inport_valid_i = 1'b1; inport_idx_i = idx; inport_data_i = d;
    @(posedge clk_i); #1;
    inport_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic flush();
    img_start_i = 1'b1;
    @(posedge clk_i); #1;
    img_start_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || outport_valid_o) && t < LIMIT) begin
      @(negedge clk_i); t++;
    end
    checks++;
    if (t >= LIMIT) begin
      errors++;
      $display("FAIL %s: drain timed out, %0d beats still expected", name, exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; img_start_i = 1'b0; inport_valid_i = 1'b0;
    inport_data_i = '0; inport_idx_i = '0; acc_mode = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_valid", 160'(outport_valid_o), 160'(0));
    chk("rst_data0", 160'(outport_data0_o), 160'(0));
    chk("rst_data3", 160'(outport_data3_o), 160'(0));
    chk("rst_idx",   160'(outport_idx_o),   160'(0));
    chk("rst_ovf",   160'(overflow_o),      160'(0));
    @(posedge clk_i); #1;

    // 1: ordered block, data = idx; first beat one cycle after completion
    for (int i = 0; i < 64; i++) wr(6'(i), DW'(i));
    @(negedge clk_i); chk("lat_not_yet", 160'(outport_valid_o), 160'(0));
    @(negedge clk_i); chk("lat_first",   160'(outport_valid_o), 160'(1));
    chk("first_data1", 160'(outport_data1_o), 160'(8));
    drain("t1");

    // 2: two blocks back to back
    for (int i = 0; i < 128; i++) wr(6'(i % 64), $urandom);
    drain("t2");
    chk("t2_ovf", 160'(overflow_o), 160'(0));

    // 3: no accept, three blocks: first beat held, third block dropped
    acc_mode = 1;
    idle(2);
    for (int i = 0; i < 192; i++) wr(6'(i % 64), $urandom);
    idle(3);
    @(negedge clk_i);
    chk("t3_valid", 160'(outport_valid_o), 160'(1));
    chk("t3_idx",   160'(outport_idx_o),   160'(0));
    chk("t3_ovf",   160'(overflow_o),      160'(1));
    chk("t3_queued_beats", 160'(exp_q.size()), 160'(32));
    @(posedge clk_i); #1;
    flush();
    acc_mode = 0;
    idle(1);
    @(negedge clk_i);
    chk("flush_valid", 160'(outport_valid_o), 160'(0));
    chk("flush_ovf",   160'(overflow_o),      160'(0));
    @(posedge clk_i); #1;

    // 4: toggling accept
    acc_mode = 2;
    for (int i = 0; i < 64; i++) wr(6'(i), $urandom);
    drain("t4");

    // 5: flush mid-block, then a fresh block
    acc_mode = 0;
    for (int i = 0; i < 20; i++) wr(6'(i), $urandom);
    flush();
    for (int i = 0; i < 64; i++) wr(6'(63 - i), $urandom);
    drain("t5");
    chk("t5_ovf", 160'(overflow_o), 160'(0));

    // Async reset mid-block, then a fresh block
    for (int i = 0; i < 30; i++) wr(6'(i), $urandom);
    #2 rst_i = 1'b1;
    #1 chk("arst_valid", 160'(outport_valid_o), 160'(0));
    @(posedge clk_i); #1 rst_i = 1'b0;
    for (int i = 0; i < 64; i++) wr(6'(i), $urandom);
    drain("arst");

    // Random indices (duplicates allowed), random gaps, random accept
    acc_mode = 3;
    for (int i = 0; i < 6 * 64; i++) begin
      wr(6'($urandom_range(0, 63)), $urandom);
      idle($urandom_range(0, 2));
    end
    drain("rand");

`ifdef JPEG_IDCT_TRANSPOSE_CLAMP_EN
    // 6: saturation of out-of-range inputs
    acc_mode = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 0)      wr(6'(i), 32'h0001_2345);
      else if (i == 1) wr(6'(i), 32'hFFFE_0000);
      else             wr(6'(i), $urandom);
    end
    idle(2);
    @(negedge clk_i);
    chk("clamp_hi", 160'(outport_data0_o), 160'(32'h0000_7FFF));
    @(posedge clk_i); #1;
    drain("clamp");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
